// File: rtl/sopc_bus_arbiter.sv
// Two-master, one-slave arbiter sharing the on-chip memory port between
// instruction fetch (m0) and data access (m1), with round-robin and slave timeout.
module sopc_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_sel,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_ack,
  output logic            m1_err,
  output logic            s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_sel,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack,
  output logic            stall_if,
  output logic            stall_mem
);

  localparam int SW = DW / 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          last_grant_reg, last_grant_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [SW-1:0] sel_reg, sel_next;

  logic          busy;
  logic          resp;
  logic          timeout_hit;
  logic          grant;
  logic [1:0]    ack_vec;
  logic [1:0]    err_vec;
  logic [DW-1:0] rdata_reg [2];

  assign busy        = (state_reg == BUSY);
  assign resp        = (state_reg == RESP);
  assign timeout_hit = busy && !s_ack && (cnt_reg == CNT_LAST);
  // On a conflict the master that did not win last time is served.
  assign grant       = (m0_req && m1_req) ? ~last_grant_reg : m1_req;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    err_next        = err_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    sel_next        = sel_reg;
    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_next      = grant;
          last_grant_next = grant;
          cnt_next        = 8'd0;
          err_next        = 1'b0;
          state_next      = BUSY;
          if (grant) begin
            we_next    = m1_we;
            addr_next  = m1_addr;
            wdata_next = m1_wdata;
            sel_next   = m1_sel;
          end else begin
            we_next    = 1'b0;
            addr_next  = m0_addr;
            wdata_next = '0;
            sel_next   = '1;
          end
        end
      end
      BUSY: begin
        if (s_ack) begin
          err_next   = 1'b0;
          state_next = RESP;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      cnt_reg        <= 8'd0;
      err_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      sel_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      sel_reg        <= sel_next;
    end
  end

  // Per-master response path: read data is captured only for the owner.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      always_ff @(posedge clk) begin
        if (!rst) begin
          rdata_reg[gi] <= '0;
        end else if (busy && (owner_reg == 1'(gi)) && (s_ack || timeout_hit)) begin
          rdata_reg[gi] <= s_ack ? s_rdata : '0;
        end
      end
      assign ack_vec[gi] = resp && (owner_reg == 1'(gi));
      assign err_vec[gi] = ack_vec[gi] && err_reg;
    end
  endgenerate

  assign m0_rdata = rdata_reg[0];
  assign m1_rdata = rdata_reg[1];
  assign m0_ack   = ack_vec[0];
  assign m1_ack   = ack_vec[1];
  assign m0_err   = err_vec[0];
  assign m1_err   = err_vec[1];

  assign s_req   = busy;
  assign s_we    = busy && we_reg;
  assign s_addr  = busy ? addr_reg  : '0;
  assign s_wdata = busy ? wdata_reg : '0;
  assign s_sel   = busy ? sel_reg   : '0;

  assign stall_if  = m0_req && !m0_ack;
  assign stall_mem = m1_req && !m1_ack;

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// Scoreboard bench for sopc_bus_arbiter: directed stimulus queues expected
// master responses and slave accesses; monitors compare as the DUT presents them.
module tb_sopc_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m0_req = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [31:0] m0_rdata;
  logic m0_ack, m0_err;
  logic m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0] m1_sel = 4'hF;
  logic [31:0] m1_rdata;
  logic m1_ack, m1_err;
  logic s_req, s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0] s_sel;
  logic s_ack;
  logic stall_if, stall_mem;

  sopc_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
    .s_rdata(s_rdata), .s_ack(s_ack), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: acks in the (slave_lat+1)-th consecutive s_req cycle.
  logic [7:0] bcnt = 8'd0;
  logic [7:0] slave_lat = 8'd0;
  bit slave_never = 1'b0;
  bit use_addr = 1'b0;
  logic [31:0] slave_data = '0;
  always @(posedge clk) bcnt <= s_req ? bcnt + 8'd1 : 8'd0;
  assign s_ack   = s_req && !slave_never && (bcnt == slave_lat);
  assign s_rdata = use_addr ? {16'hA5A5, s_addr[15:0]} : slave_data;

  typedef struct { logic err; logic chk_data; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel; } acc_t;
  resp_t q0[$];
  resp_t q1[$];
  acc_t  sq[$];
  acc_t  cur;
  resp_t e0, e1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (m0_ack) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL m0_ack_unexpected: got ack=1 expected no ack (cycle %0d)", cyc);
        end else begin
          e0 = q0.pop_front();
          chk("m0_err", 64'(m0_err), 64'(e0.err));
          if (e0.chk_data) chk("m0_rdata", 64'(m0_rdata), 64'(e0.rdata));
          chk("m0_ack_cycle", 64'(cyc), 64'(e0.cyc));
        end
      end else if (m0_err) begin
        n_cmp++; n_bad++;
        $display("FAIL m0_err_without_ack: got err=1 expected 0 (cycle %0d)", cyc);
      end
      if (m1_ack) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL m1_ack_unexpected: got ack=1 expected no ack (cycle %0d)", cyc);
        end else begin
          e1 = q1.pop_front();
          chk("m1_err", 64'(m1_err), 64'(e1.err));
          if (e1.chk_data) chk("m1_rdata", 64'(m1_rdata), 64'(e1.rdata));
          chk("m1_ack_cycle", 64'(cyc), 64'(e1.cyc));
        end
      end else if (m1_err) begin
        n_cmp++; n_bad++;
        $display("FAIL m1_err_without_ack: got err=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  // Slave-side monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_req) begin
        if (bcnt == 8'd0) begin
          if (sq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL s_req_unexpected: got s_req=1 expected 0 (cycle %0d)", cyc);
          end else begin
            cur = sq.pop_front();
          end
        end
        chk("s_we", 64'(s_we), 64'(cur.we));
        chk("s_addr", 64'(s_addr), 64'(cur.addr));
        chk("s_wdata", 64'(s_wdata), 64'(cur.wdata));
        chk("s_sel", 64'(s_sel), 64'(cur.sel));
      end else begin
        chk("s_idle_we_sel", 64'({s_we, s_sel}), 64'd0);
        chk("s_idle_addr", 64'(s_addr), 64'd0);
        chk("s_idle_wdata", 64'(s_wdata), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int scount;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    chk("rst_m0_rdata", 64'(m0_rdata), 64'd0);
    chk("rst_m1_rdata", 64'(m1_rdata), 64'd0);
    mon_en = 1'b1;

    // Single fetch, slave acks in the same cycle
    slave_lat = 8'd0; slave_data = 32'h3C011234; use_addr = 1'b0;
    next_cycle(); t0 = cyc;
    q0.push_back('{1'b0, 1'b1, 32'h3C011234, t0 + 2});
    sq.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
    m0_addr = 32'h100; m0_req = 1'b1;
    @(negedge clk); chk("fetch_stall_if_c0", 64'(stall_if), 64'd1);
    chk("fetch_stall_mem", 64'(stall_mem), 64'd0);
    @(negedge clk); chk("fetch_stall_if_c1", 64'(stall_if), 64'd1);
    @(negedge clk); chk("fetch_stall_if_c2", 64'(stall_if), 64'd0);
    next_cycle(); m0_req = 1'b0;
    repeat (2) next_cycle();

    // Single write, ack in the third BUSY cycle; master changes data mid-BUSY
    slave_lat = 8'd2; slave_data = 32'h11111111;
    next_cycle(); t0 = cyc;
    q1.push_back('{1'b0, 1'b0, 32'h0, t0 + 4});
    sq.push_back('{1'b1, 32'h20, 32'hDEADBEEF, 4'b0011});
    m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF; m1_sel = 4'b0011; m1_req = 1'b1;
    next_cycle();
    next_cycle(); m1_wdata = 32'h0BADF00D; m1_addr = 32'h999; m1_sel = 4'hF;
    @(negedge clk); chk("write_stall_mem_c2", 64'(stall_mem), 64'd1);
    next_cycle();
    next_cycle();
    @(negedge clk); chk("write_stall_mem_c4", 64'(stall_mem), 64'd0);
    next_cycle(); m1_req = 1'b0; m1_we = 1'b0; m1_wdata = '0; m1_sel = 4'hF;
    repeat (2) next_cycle();

    // Conflict after reset: m1, m0, m1, m0
    rst = 1'b0; next_cycle(); next_cycle(); rst = 1'b1;
    slave_lat = 8'd0; use_addr = 1'b1;
    next_cycle(); t0 = cyc;
    q1.push_back('{1'b0, 1'b1, 32'hA5A50300, t0 + 2});
    q0.push_back('{1'b0, 1'b1, 32'hA5A50200, t0 + 5});
    q1.push_back('{1'b0, 1'b1, 32'hA5A50300, t0 + 8});
    q0.push_back('{1'b0, 1'b1, 32'hA5A50200, t0 + 11});
    sq.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
    sq.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    sq.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
    sq.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    m0_addr = 32'h200; m1_addr = 32'h300; m1_we = 1'b0; m1_sel = 4'hF;
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (12) next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) next_cycle();

    // Timeout: slave never acks, TIMEOUT=4
    slave_never = 1'b1; use_addr = 1'b0;
    next_cycle(); t0 = cyc;
    q0.push_back('{1'b1, 1'b1, 32'h0, t0 + 5});
    sq.push_back('{1'b0, 32'h40, 32'h0, 4'hF});
    m0_addr = 32'h40; m0_req = 1'b1;
    scount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_req) scount++;
    end
    chk("timeout_s_req_cycles", 64'(scount), 64'd4);
    next_cycle(); m0_req = 1'b0;
    @(negedge clk); chk("timeout_back_idle", 64'({s_req, m0_ack}), 64'd0);
    slave_never = 1'b0;
    repeat (2) next_cycle();

    // Reset in the second BUSY cycle of an m1 access
    slave_never = 1'b1;
    next_cycle();
    sq.push_back('{1'b0, 32'h500, 32'h0, 4'hC});
    m1_addr = 32'h500; m1_sel = 4'hC; m1_req = 1'b1;
    next_cycle();
    next_cycle(); rst = 1'b0;
    next_cycle(); rst = 1'b1; m1_req = 1'b0; m1_sel = 4'hF;
    @(negedge clk);
    chk("midrst_s_req", 64'(s_req), 64'd0);
    chk("midrst_m1_ack", 64'(m1_ack), 64'd0);
    chk("midrst_m1_rdata", 64'(m1_rdata), 64'd0);
    slave_never = 1'b0; slave_lat = 8'd0; use_addr = 1'b1;
    next_cycle(); t0 = cyc;
    q1.push_back('{1'b0, 1'b1, 32'hA5A50700, t0 + 2});
    q0.push_back('{1'b0, 1'b1, 32'hA5A50600, t0 + 5});
    sq.push_back('{1'b0, 32'h700, 32'h0, 4'hF});
    sq.push_back('{1'b0, 32'h600, 32'h0, 4'hF});
    m0_addr = 32'h600; m1_addr = 32'h700; m0_req = 1'b1; m1_req = 1'b1;
    repeat (3) next_cycle(); m1_req = 1'b0;
    repeat (3) next_cycle(); m0_req = 1'b0;
    repeat (2) next_cycle();

    // Request withdrawal during BUSY
    use_addr = 1'b0; slave_lat = 8'd2; slave_data = 32'hCAFEF00D;
    next_cycle(); t0 = cyc;
    q0.push_back('{1'b0, 1'b1, 32'hCAFEF00D, t0 + 4});
    sq.push_back('{1'b0, 32'h800, 32'h0, 4'hF});
    m0_addr = 32'h800; m0_req = 1'b1;
    next_cycle();
    next_cycle(); m0_req = 1'b0;
    @(negedge clk); chk("withdraw_stall_if", 64'(stall_if), 64'd0);
    repeat (8) next_cycle();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("sq_drained", 64'(sq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
